// File: rtl/ycbcr_capture_pkg.sv
// Shared definitions for the YCbCr 4:2:2 camera capture path and its downstream
// consumers (e.g. the colour detector): default frame geometry, coordinate
// widths, pixel payload and capture FSM state encodings.
package ycbcr_capture_pkg;

  // Default frame geometry (VGA)
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  // Datapath and coordinate widths
  localparam int unsigned PIX_W = 8;
  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;

  // Capture FSM encodings; the B_* states name the byte expected next
  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_WAIT_FRAME = 3'd0;
  localparam logic [ST_W-1:0] ST_WAIT_LINE  = 3'd1;
  localparam logic [ST_W-1:0] ST_B_CB       = 3'd2;
  localparam logic [ST_W-1:0] ST_B_Y0       = 3'd3;
  localparam logic [ST_W-1:0] ST_B_CR       = 3'd4;
  localparam logic [ST_W-1:0] ST_B_Y1       = 3'd5;

  // One assembled pixel
  typedef struct packed {
    logic [PIX_W-1:0] y;
    logic [PIX_W-1:0] cb;
    logic [PIX_W-1:0] cr;
  } ycbcr_pix_t;

endpackage

// File: rtl/pixel_coord_counter.sv
// Column/row counters for the capture path.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   col_clr, col_inc  - clear / increment the column counter (clear wins)
//   row_clr, row_inc  - clear / increment the row counter (clear wins)
//   col, row          - current column and row (registered)
module pixel_coord_counter
  import ycbcr_capture_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           col_clr,
  input  logic           col_inc,
  input  logic           row_clr,
  input  logic           row_inc,
  output logic [X_W-1:0] col,
  output logic [Y_W-1:0] row
);

  // Both counters saturate so an over-long line or frame can never wrap
  // back into the active window.
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else begin
      if (col_clr) begin
        col <= '0;
      end else if (col_inc && (col != '1)) begin
        col <= col + X_W'(1);
      end
      if (row_clr) begin
        row <= '0;
      end else if (row_inc && (row != '1)) begin
        row <= row + Y_W'(1);
      end
    end
  end

endmodule

// File: rtl/ycbcr_capture.sv
// YCbCr 4:2:2 camera capture: assembles the Cb,Y0,Cr,Y1 byte stream into
// pixels with column/row coordinates, one PCLK after the completing byte.
// Ports:
//   PCLK, reset     - pixel clock, synchronous active-high reset
//   VSYNC, HREF, D  - camera frame sync, line valid, byte bus
//   e_pix           - one-cycle strobe: Y/Cb/Cr/x/y hold a complete pixel
//   Y, Cb, Cr       - pixel components (held between strobes)
//   x, y            - pixel column / row (held between strobes)
//   frame_done      - one-cycle strobe at the end of a frame with pixels
//   overrun         - sticky: data beyond H_ACTIVE/V_ACTIVE in this frame
module ycbcr_capture
  import ycbcr_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic             PCLK,
  input  logic             reset,
  input  logic             VSYNC,
  input  logic             HREF,
  input  logic [PIX_W-1:0] D,
  output logic             e_pix,
  output logic [PIX_W-1:0] Y,
  output logic [PIX_W-1:0] Cb,
  output logic [PIX_W-1:0] Cr,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic             frame_done,
  output logic             overrun
);

  localparam logic [X_W-1:0] H_LIM = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] V_LIM = Y_W'(V_ACTIVE);

  logic [ST_W-1:0]  state;
  logic [ST_W-1:0]  state_nxt;
  logic             vsync_q;
  logic             frame_start_c;
  logic             abort_c;
  logic             line_end_c;
  logic             ld_cb_c;
  logic             ld_y0_c;
  logic             ld_cr_c;
  logic             ld_y1_c;
  logic             complete_c;
  logic             in_range_c;
  logic             emit_c;
  logic [X_W-1:0]   col;
  logic [Y_W-1:0]   row;
  logic [PIX_W-1:0] y0_q;
  logic [PIX_W-1:0] cb_q;
  logic [PIX_W-1:0] cr_q;
  logic             pend;
  ycbcr_pix_t       pend_pix;
  logic [X_W-1:0]   pend_x;
  logic [Y_W-1:0]   pend_row;
  logic             line_pix;
  logic             frame_pix;

  // State register
  always_ff @(posedge PCLK) begin
    if (reset) begin
      state <= ST_WAIT_FRAME;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-edge control strobes; VSYNC takes priority over bytes
  always_comb begin
    state_nxt     = state;
    frame_start_c = 1'b0;
    abort_c       = 1'b0;
    line_end_c    = 1'b0;
    ld_cb_c       = 1'b0;
    ld_y0_c       = 1'b0;
    ld_cr_c       = 1'b0;
    ld_y1_c       = 1'b0;
    case (state)
      ST_WAIT_FRAME: begin
        if (vsync_q && !VSYNC) begin
          state_nxt     = ST_WAIT_LINE;
          frame_start_c = 1'b1;
        end
      end
      ST_WAIT_LINE, ST_B_CB, ST_B_Y0, ST_B_CR, ST_B_Y1: begin
        if (VSYNC) begin
          state_nxt = ST_WAIT_FRAME;
          abort_c   = 1'b1;
        end else if (!HREF) begin
          // HREF falling inside a line drops any partial group
          state_nxt  = ST_WAIT_LINE;
          line_end_c = (state != ST_WAIT_LINE);
        end else begin
          case (state)
            ST_WAIT_LINE, ST_B_CB: begin
              ld_cb_c   = 1'b1;
              state_nxt = ST_B_Y0;
            end
            ST_B_Y0: begin
              ld_y0_c   = 1'b1;
              state_nxt = ST_B_CR;
            end
            ST_B_CR: begin
              ld_cr_c   = 1'b1;
              state_nxt = ST_B_Y1;
            end
            ST_B_Y1: begin
              ld_y1_c   = 1'b1;
              state_nxt = ST_B_CB;
            end
            default: state_nxt = ST_WAIT_FRAME;
          endcase
        end
      end
      default: state_nxt = ST_WAIT_FRAME;
    endcase
  end

  assign complete_c = ld_cr_c | ld_y1_c;
  assign in_range_c = (col < H_LIM) && (row < V_LIM);
  assign emit_c     = complete_c & in_range_c;

  pixel_coord_counter u_coord (
    .clk     (PCLK),
    .reset   (reset),
    .col_clr (frame_start_c | abort_c | line_end_c),
    .col_inc (complete_c),
    .row_clr (frame_start_c),
    .row_inc (line_end_c & line_pix),
    .col     (col),
    .row     (row)
  );

  // Byte latches, one-deep pixel stage and registered outputs
  always_ff @(posedge PCLK) begin
    if (reset) begin
      vsync_q    <= 1'b0;
      y0_q       <= '0;
      cb_q       <= '0;
      cr_q       <= '0;
      pend       <= 1'b0;
      pend_pix   <= '0;
      pend_x     <= '0;
      pend_row   <= '0;
      line_pix   <= 1'b0;
      frame_pix  <= 1'b0;
      e_pix      <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      Y          <= '0;
      Cb         <= '0;
      Cr         <= '0;
      x          <= '0;
      y          <= '0;
    end else begin
      vsync_q    <= VSYNC;
      e_pix      <= pend;
      frame_done <= abort_c & frame_pix;
      if (pend) begin
        Y  <= pend_pix.y;
        Cb <= pend_pix.cb;
        Cr <= pend_pix.cr;
        x  <= pend_x;
        y  <= pend_row;
      end

      if (ld_cb_c) cb_q <= D;
      if (ld_y0_c) y0_q <= D;
      if (ld_cr_c) cr_q <= D;

      // Stage the completed pixel so it appears exactly one edge later
      pend <= emit_c;
      if (complete_c) begin
        pend_pix.y  <= ld_cr_c ? y0_q : D;
        pend_pix.cb <= cb_q;
        pend_pix.cr <= ld_cr_c ? D : cr_q;
        pend_x      <= col;
        pend_row    <= row;
      end

      if (frame_start_c) begin
        frame_pix <= 1'b0;
        overrun   <= 1'b0;
      end else begin
        if (emit_c) frame_pix <= 1'b1;
        if (complete_c && !in_range_c) overrun <= 1'b1;
      end

      // A line only advances the row if it completed at least one pixel
      if (frame_start_c || abort_c || line_end_c) begin
        line_pix <= 1'b0;
      end else if (complete_c) begin
        line_pix <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ycbcr_capture.sv
`timescale 1ns/1ps
// Bench for ycbcr_capture: directed scenarios plus randomized frames, each
// cycle compared with a byte-stream reference model.
module tb_ycbcr_capture;

  localparam int unsigned H_ACT = 4;
  localparam int unsigned V_ACT = 3;

  logic       PCLK = 1'b0;
  logic       reset;
  logic       VSYNC;
  logic       HREF;
  logic [7:0] D;
  logic       e_pix;
  logic [7:0] Y;
  logic [7:0] Cb;
  logic [7:0] Cr;
  logic [9:0] x;
  logic [8:0] y;
  logic       frame_done;
  logic       overrun;

  ycbcr_capture #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT)) dut (
    .PCLK       (PCLK),
    .reset      (reset),
    .VSYNC      (VSYNC),
    .HREF       (HREF),
    .D          (D),
    .e_pix      (e_pix),
    .Y          (Y),
    .Cb         (Cb),
    .Cr         (Cr),
    .x          (x),
    .y          (y),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes of the current line are kept in an array; a pixel
  // completes on byte k of the line when k mod 4 is 2 (Y0) or 3 (Y1).
  logic       m_armed, m_prev_vs, m_line_pix, m_frame_pix, m_overrun, m_pend;
  int         m_nb, m_row, m_px, m_prow;
  logic [7:0] m_bytes [64];
  logic [7:0] m_py, m_pcb, m_pcr;
  logic       exp_epix, exp_fd;
  logic [7:0] exp_y, exp_cb, exp_cr;
  int         exp_x, exp_row;

  task automatic model_step(input logic r, input logic vs, input logic hr, input logic [7:0] d);
    int k, g, idx;
    if (r) begin
      m_armed = 0; m_prev_vs = 0; m_nb = 0; m_row = 0; m_line_pix = 0;
      m_frame_pix = 0; m_overrun = 0; m_pend = 0;
      exp_epix = 0; exp_fd = 0; exp_y = 0; exp_cb = 0; exp_cr = 0; exp_x = 0; exp_row = 0;
    end else begin
      exp_epix = m_pend;
      exp_fd   = 0;
      if (m_pend) begin
        exp_y = m_py; exp_cb = m_pcb; exp_cr = m_pcr; exp_x = m_px; exp_row = m_prow;
      end
      m_pend = 0;
      if (!m_armed) begin
        if (m_prev_vs && !vs) begin
          m_armed = 1; m_nb = 0; m_row = 0; m_line_pix = 0; m_frame_pix = 0; m_overrun = 0;
        end
      end else if (vs) begin
        exp_fd = m_frame_pix; m_armed = 0; m_nb = 0; m_line_pix = 0;
      end else if (hr) begin
        k = m_nb;
        g = k - (k % 4);
        if (k < 64) m_bytes[k] = d;
        m_nb++;
        if ((k % 4) >= 2 && k < 64) begin
          idx = (k / 4) * 2 + (k % 4) - 2;
          m_line_pix = 1;
          if (idx < int'(H_ACT) && m_row < int'(V_ACT)) begin
            m_pend = 1;
            m_py   = ((k % 4) == 2) ? m_bytes[k-1] : m_bytes[k];
            m_pcb  = m_bytes[g];
            m_pcr  = m_bytes[g+2];
            m_px   = idx;
            m_prow = m_row;
            m_frame_pix = 1;
          end else begin
            m_overrun = 1;
          end
        end
      end else if (m_nb > 0) begin
        if (m_line_pix) m_row++;
        m_nb = 0;
        m_line_pix = 0;
      end
      m_prev_vs = vs;
    end
  endtask

  typedef struct {
    logic [7:0] py;
    logic [7:0] pcb;
    logic [7:0] pcr;
    int         px;
    int         prow;
  } pix_rec_t;

  pix_rec_t plog[$];
  int       fd_cnt = 0;

  // One PCLK: drive at the falling edge, model at the rising edge, check 1ns later
  task automatic cycle(input logic r, input logic vs, input logic hr, input logic [7:0] d);
    pix_rec_t rec;
    reset = r; VSYNC = vs; HREF = hr; D = d;
    @(posedge PCLK);
    model_step(r, vs, hr, d);
    #1;
    check_val("e_pix", 32'(e_pix), 32'(exp_epix));
    check_val("frame_done", 32'(frame_done), 32'(exp_fd));
    check_val("overrun", 32'(overrun), 32'(m_overrun));
    check_val("Y", 32'(Y), 32'(exp_y));
    check_val("Cb", 32'(Cb), 32'(exp_cb));
    check_val("Cr", 32'(Cr), 32'(exp_cr));
    check_val("x", 32'(x), 32'(exp_x));
    check_val("y", 32'(y), 32'(exp_row));
    if (e_pix === 1'b1) begin
      rec.py = Y; rec.pcb = Cb; rec.pcr = Cr; rec.px = int'(x); rec.prow = int'(y);
      plog.push_back(rec);
    end
    if (frame_done === 1'b1) fd_cnt++;
    @(negedge PCLK);
  endtask

  task automatic idle(input int n, input logic vs);
    for (int i = 0; i < n; i++) cycle(1'b0, vs, 1'b0, 8'($urandom));
  endtask

  task automatic line_rand(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, nbytes;
    reset = 1'b1; VSYNC = 1'b1; HREF = 1'b0; D = 8'h00;
    @(negedge PCLK);

    // Reset state
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check_val("rst_e_pix", 32'(e_pix), 32'd0);
    check_val("rst_overrun", 32'(overrun), 32'd0);
    check_val("rst_x", 32'(x), 32'd0);

    // Basic two-pixel group
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    idle(2, 1'b0);
    plog.delete();
    cycle(1'b0, 1'b0, 1'b1, 8'h80);
    cycle(1'b0, 1'b0, 1'b1, 8'h10);
    cycle(1'b0, 1'b0, 1'b1, 8'h90);
    check_val("a_nopix_yet", 32'(plog.size()), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'h20);
    check_val("a_pix0_lat", 32'(plog.size()), 32'd1);
    idle(2, 1'b0);
    check_val("a_npix", 32'(plog.size()), 32'd2);
    if (plog.size() == 2) begin
      check_val("a_y0", 32'(plog[0].py), 32'h10);
      check_val("a_cb0", 32'(plog[0].pcb), 32'h80);
      check_val("a_cr0", 32'(plog[0].pcr), 32'h90);
      check_val("a_x0", 32'(plog[0].px), 32'd0);
      check_val("a_y1", 32'(plog[1].py), 32'h20);
      check_val("a_x1", 32'(plog[1].px), 32'd1);
    end

    // Partial group dropped, next line at x=0, y=1
    plog.delete();
    cycle(1'b0, 1'b0, 1'b1, 8'h81);
    cycle(1'b0, 1'b0, 1'b1, 8'h11);
    idle(2, 1'b0);
    check_val("b_partial", 32'(plog.size()), 32'd0);
    line_rand(4);
    idle(2, 1'b0);
    check_val("b_npix", 32'(plog.size()), 32'd2);
    if (plog.size() > 0) begin
      check_val("b_x", 32'(plog[0].px), 32'd0);
      check_val("b_row", 32'(plog[0].prow), 32'd1);
    end
    fd_cnt = 0;
    idle(2, 1'b1);
    check_val("b_fd", 32'(fd_cnt), 32'd1);

    // Two lines of four pixels, then frame end
    plog.delete(); fd_cnt = 0;
    idle(2, 1'b0);
    line_rand(8); idle(2, 1'b0);
    line_rand(8); idle(2, 1'b0);
    idle(3, 1'b1);
    check_val("c_fd", 32'(fd_cnt), 32'd1);
    check_val("c_npix", 32'(plog.size()), 32'd8);
    if (plog.size() > 0) begin
      check_val("c_last_x", 32'(plog[$].px), 32'd3);
      check_val("c_last_row", 32'(plog[$].prow), 32'd1);
    end

    // Horizontal then vertical overrun; clears at the next frame start
    plog.delete();
    idle(2, 1'b0);
    line_rand(12); idle(2, 1'b0);
    check_val("d_npix", 32'(plog.size()), 32'd4);
    for (int i = 0; i < plog.size(); i++) check_val("d_x", 32'(plog[i].px), 32'(i));
    check_val("d_overrun", 32'(overrun), 32'd1);
    line_rand(8); idle(2, 1'b0);
    line_rand(8); idle(2, 1'b0);
    line_rand(4); idle(2, 1'b0);
    check_val("d_vlimit", 32'(plog.size()), 32'd12);
    idle(2, 1'b1);
    check_val("d_sticky", 32'(overrun), 32'd1);
    idle(1, 1'b0);
    check_val("d_clear", 32'(overrun), 32'd0);

    // Reset after Cr: no pixel, outputs zero, no capture until VSYNC falls
    plog.delete();
    cycle(1'b0, 1'b0, 1'b1, 8'h11);
    cycle(1'b0, 1'b0, 1'b1, 8'h22);
    cycle(1'b0, 1'b0, 1'b1, 8'h33);
    cycle(1'b1, 1'b0, 1'b1, 8'h44);
    check_val("e_rst_epix", 32'(e_pix), 32'd0);
    check_val("e_rst_y", 32'(Y), 32'd0);
    check_val("e_rst_cb", 32'(Cb), 32'd0);
    idle(2, 1'b0);
    line_rand(8); idle(2, 1'b0);
    check_val("e_no_capture", 32'(plog.size()), 32'd0);
    idle(1, 1'b1); idle(1, 1'b0);
    line_rand(4); idle(2, 1'b0);
    check_val("e_resume", 32'(plog.size()), 32'd2);

    // VSYNC and completing byte on the same edge
    plog.delete(); fd_cnt = 0;
    line_rand(6);
    cycle(1'b0, 1'b1, 1'b1, 8'h5a);
    idle(2, 1'b1);
    check_val("f_npix", 32'(plog.size()), 32'd2);
    check_val("f_fd", 32'(fd_cnt), 32'd1);

    // Randomized frames
    for (int f = 0; f < 60; f++) begin
      for (int i = 0; i < int'($urandom_range(1, 3)); i++)
        cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
      nl = int'($urandom_range(0, 5));
      for (int l = 0; l < nl; l++) begin
        idle(int'($urandom_range(1, 3)), 1'b0);
        nbytes = int'($urandom_range(0, 14));
        for (int b = 0; b < nbytes; b++) begin
          if ($urandom_range(0, 59) == 0)
            cycle(1'b0, 1'b1, 1'b1, 8'($urandom));
          else if ($urandom_range(0, 99) == 0)
            cycle(1'b1, 1'b0, 1'b1, 8'($urandom));
          else
            cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
        end
      end
      idle(int'($urandom_range(1, 2)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
